cd_toggle_monitor: RTL and testbench
====================================

Name: cd_toggle_monitor

Overview:
- Single-clock consumer that sits directly downstream of the Aclk→Bclk toggle-transfer stage, in the Bclk domain.
- Takes the transferred toggle bit (the crossing stage's Dout), resynchronises it and detects each toggle.
- Measures the Bclk-cycle gap between toggles and checks it against a window; declares lock after a run of good gaps.
- Reports short/long-gap errors and keeps toggle/error counters for bring-up and hardware test.

Parameters:
- SYNC_STAGES, 2, number of Bclk flops on din before edge detection (0 allowed)
- MIN_GAP, 1, smallest legal gap in Bclk cycles (>=1)
- MAX_GAP, 4, largest legal gap in Bclk cycles (>=MIN_GAP, < 2**GAP_W-1)
- LOCK_COUNT, 8, consecutive in-window gaps required to assert locked
- GAP_W, 8, width of gap measurement
- CNT_W, 16, width of toggle_count and error_count

Ports:
- Bclk  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- din  input  1  toggle bit from crossing stage (Dout)
- clear_errs  input  1  synchronous clear of error_count
- toggle_pulse  output  1  one-cycle pulse per detected din transition
- gap  output  GAP_W  last measured gap, held until next measurement
- gap_valid  output  1  one-cycle pulse when gap updates
- locked  output  1  high in TRACK state
- err_short  output  1  one-cycle pulse, gap < MIN_GAP in TRACK
- err_long  output  1  one-cycle pulse, gap > MAX_GAP or timeout in TRACK
- toggle_count  output  CNT_W  total toggles, wraps
- error_count  output  CNT_W  total errors, saturates

Behaviour:
- Reset (sync, high): all outputs 0, sync chain and previous-value flop 0, gap_cnt 0, good_cnt 0, state IDLE.
- Edge detect: s = din after SYNC_STAGES flops; prev = s delayed 1 cycle; toggle when s != prev. toggle_pulse is registered and high exactly 1 cycle, SYNC_STAGES+1 cycles after the first Bclk edge sampling the new din.
- gap_cnt: on a toggle it loads 1; otherwise it increments and saturates at all-ones. A gap is the value of gap_cnt at the toggle, so back-to-back toggle cycles give gap=1.
- At each toggle except the first after IDLE: gap <= gap_cnt, and gap_valid pulses in the same cycle as toggle_pulse.
- In-window means MIN_GAP <= gap <= MAX_GAP.
- Timeout occurs in the cycle gap_cnt reaches MAX_GAP+1 with no toggle. It fires once per gap; a later toggle closing that gap produces no second error and no gap_valid.
- State IDLE: locked=0. First toggle → ACQ, good_cnt=0.
- State ACQ: an in-window gap increments good_cnt. When good_cnt reaches LOCK_COUNT → TRACK.
  - An out-of-window gap clears good_cnt and stays in ACQ.
  - A timeout → IDLE.
  - No err pulses and no error_count changes in ACQ.
- State TRACK: locked=1.
  - Short gap → err_short pulse; long gap → err_long pulse. Both stay in TRACK with error_count+1.
  - Timeout → err_long pulse, error_count+1, → IDLE, locked drops next cycle.
- toggle_count increments on every toggle_pulse in all states and wraps modulo 2**CNT_W.
- error_count saturates at all-ones. clear_errs takes priority over a same-cycle increment (result 0).
- Reset mid-operation: all state is discarded next cycle. The first toggle after release re-enters ACQ via IDLE.
- Simultaneous toggle and timeout threshold: the toggle wins, and the gap is evaluated normally.

Decomposition:
- Shared package cd_mon_pkg holds:
  - state encodings IDLE/ACQ/TRACK (2-bit)
  - default MIN_GAP/MAX_GAP/LOCK_COUNT constants derived from 27.7 MHz/50 MHz
- Sub-module edge_sync: SYNC_STAGES flop chain, prev flop and registered toggle_pulse. Reused by other Bclk-domain consumers.

Test Plan:
- Reset held 3 cycles, din static → all outputs 0, state IDLE, toggle_count 0.
- din toggles every 2 Bclk cycles for 12 toggles → first toggle_pulse 3 cycles after first sample (SYNC_STAGES=2), gap=2 on each gap_valid, locked rises after 8th good gap, toggle_count=12, error_count=0.
- Locked, then din held 10 cycles → single err_long exactly 5 cycles after last toggle (MAX_GAP=4), error_count=1, locked falls, next toggle gives no gap_valid.
- Locked, one gap of 6 cycles followed by toggle → err_long at the timeout only, not again at the toggle.
- MIN_GAP=2, locked, two toggles 1 cycle apart → err_short pulse, gap=1, locked stays 1.
- error_count forced near all-ones then 3 errors → saturates at 16'hFFFF. clear_errs in the same cycle as an error → 0. Reset asserted mid-ACQ → good_cnt 0, state IDLE.

Source files
------------

// File: rtl/cd_mon_pkg.sv
// Shared definitions for Bclk-domain consumers of the Aclk->Bclk toggle-transfer stage.
package cd_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACQ   = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  // Aclk 27.7 MHz toggling into Bclk 50 MHz gives a nominal gap of ~1.8 Bclk cycles;
  // the upper bound leaves two cycles of slack above the rounded-up nominal gap.
  localparam int unsigned ACLK_KHZ       = 27700;
  localparam int unsigned BCLK_KHZ       = 50000;
  localparam int unsigned DEF_MIN_GAP    = 1;
  localparam int unsigned DEF_MAX_GAP    = (BCLK_KHZ + ACLK_KHZ - 1) / ACLK_KHZ + 2;
  localparam int unsigned DEF_LOCK_COUNT = 8;

endpackage

// File: rtl/cd_toggle_monitor_if.sv
// Control/status bundle between the toggle monitor and its user.
interface cd_toggle_monitor_if #(
  parameter int unsigned GAP_W = 8,
  parameter int unsigned CNT_W = 16
);
  logic             din;
  logic             clear_errs;
  logic             toggle_pulse;
  logic [GAP_W-1:0] gap;
  logic             gap_valid;
  logic             locked;
  logic             err_short;
  logic             err_long;
  logic [CNT_W-1:0] toggle_count;
  logic [CNT_W-1:0] error_count;

  modport master (
    output din, clear_errs,
    input  toggle_pulse, gap, gap_valid, locked, err_short, err_long,
           toggle_count, error_count
  );

  modport slave (
    input  din, clear_errs,
    output toggle_pulse, gap, gap_valid, locked, err_short, err_long,
           toggle_count, error_count
  );
endinterface

// File: rtl/cd_toggle_monitor_edge_sync.sv
// Resynchronises a toggle bit into the local clock and flags each transition.
module edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_toggle,
  output logic o_toggle_pulse
);
  logic w_s;
  logic r_prev;
  logic r_toggle_pulse;

  if (SYNC_STAGES == 0) begin : g_nosync
    assign w_s = i_din;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] r_sync;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_sync <= '0;
      end else begin
        r_sync[0] <= i_din;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      end
    end
    assign w_s = r_sync[SYNC_STAGES-1];
  end

  // o_toggle is the unregistered detect so consumers can register results alongside the pulse
  assign o_toggle = w_s ^ r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev         <= 1'b0;
      r_toggle_pulse <= 1'b0;
    end else begin
      r_prev         <= w_s;
      r_toggle_pulse <= o_toggle;
    end
  end

  assign o_toggle_pulse = r_toggle_pulse;
endmodule

// File: rtl/cd_toggle_monitor.sv
// Bclk-domain monitor for the toggle-transfer stage: gap measurement, lock tracking, error counts.
module cd_toggle_monitor
  import cd_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_GAP     = DEF_MIN_GAP,
  parameter int unsigned MAX_GAP     = DEF_MAX_GAP,
  parameter int unsigned LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int unsigned GAP_W       = 8,
  parameter int unsigned CNT_W       = 16
) (
  input logic                Bclk,
  input logic                reset,
  cd_toggle_monitor_if.slave bus
);
  localparam int unsigned    GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [GAP_W-1:0] MIN_G = GAP_W'(MIN_GAP);
  localparam logic [GAP_W-1:0] MAX_G = GAP_W'(MAX_GAP);
  localparam logic [GAP_W-1:0] TMO_G = GAP_W'(MAX_GAP + 1);

  state_t              r_state;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [GOOD_W-1:0]   r_good_cnt;
  logic [GAP_W-1:0]    r_gap;
  logic                r_gap_valid;
  logic                r_locked;
  logic                r_err_short;
  logic                r_err_long;
  logic [CNT_W-1:0]    r_toggle_count;
  logic [CNT_W-1:0]    r_error_count;

  logic w_toggle;
  logic w_toggle_pulse;
  logic w_short;
  logic w_in_win;
  logic w_timeout;
  logic w_err;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_edge_sync (
    .i_clk          (Bclk),
    .i_rst          (reset),
    .i_din          (bus.din),
    .o_toggle       (w_toggle),
    .o_toggle_pulse (w_toggle_pulse)
  );

  assign w_short   = r_gap_cnt < MIN_G;
  assign w_in_win  = !w_short && (r_gap_cnt <= MAX_G);
  // A toggle landing on the timeout threshold is judged as an ordinary (long) gap
  assign w_timeout = !w_toggle && (r_gap_cnt == TMO_G);
  assign w_err     = (r_state == ST_TRACK) && (w_toggle ? !w_in_win : w_timeout);

  always_ff @(posedge Bclk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_gap_cnt      <= '0;
      r_good_cnt     <= '0;
      r_gap          <= '0;
      r_gap_valid    <= 1'b0;
      r_locked       <= 1'b0;
      r_err_short    <= 1'b0;
      r_err_long     <= 1'b0;
      r_toggle_count <= '0;
      r_error_count  <= '0;
    end else begin
      r_gap_valid <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;

      if (w_toggle)                r_gap_cnt <= GAP_W'(1);
      else if (r_gap_cnt != '1)    r_gap_cnt <= r_gap_cnt + 1'b1;

      if (w_toggle) r_toggle_count <= r_toggle_count + 1'b1;

      if (bus.clear_errs)                      r_error_count <= '0;
      else if (w_err && r_error_count != '1)   r_error_count <= r_error_count + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_toggle) begin
            r_state    <= ST_ACQ;
            r_good_cnt <= '0;
          end
        end
        ST_ACQ: begin
          if (w_toggle) begin
            r_gap       <= r_gap_cnt;
            r_gap_valid <= 1'b1;
            if (!w_in_win) begin
              r_good_cnt <= '0;
            end else if (r_good_cnt + 1'b1 == GOOD_W'(LOCK_COUNT)) begin
              r_good_cnt <= r_good_cnt + 1'b1;
              r_state    <= ST_TRACK;
              r_locked   <= 1'b1;
            end else begin
              r_good_cnt <= r_good_cnt + 1'b1;
            end
          end else if (w_timeout) begin
            r_state    <= ST_IDLE;
            r_good_cnt <= '0;
          end
        end
        ST_TRACK: begin
          if (w_toggle) begin
            r_gap       <= r_gap_cnt;
            r_gap_valid <= 1'b1;
            if (w_short)        r_err_short <= 1'b1;
            else if (!w_in_win) r_err_long  <= 1'b1;
          end else if (w_timeout) begin
            r_err_long <= 1'b1;
            r_state    <= ST_IDLE;
            r_locked   <= 1'b0;
            r_good_cnt <= '0;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign bus.toggle_pulse = w_toggle_pulse;
  assign bus.gap          = r_gap;
  assign bus.gap_valid    = r_gap_valid;
  assign bus.locked       = r_locked;
  assign bus.err_short    = r_err_short;
  assign bus.err_long     = r_err_long;
  assign bus.toggle_count = r_toggle_count;
  assign bus.error_count  = r_error_count;
endmodule

// File: tb/tb_cd_toggle_monitor.sv
// Directed bench for cd_toggle_monitor: default instance plus a MIN_GAP=2 / 3-bit-counter instance.
module tb_cd_toggle_monitor;
  import cd_mon_pkg::*;

  logic Bclk    = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 Bclk = ~Bclk;

  cd_toggle_monitor_if #(.GAP_W(8), .CNT_W(16)) bus_a ();
  cd_toggle_monitor_if #(.GAP_W(8), .CNT_W(3))  bus_b ();

  cd_toggle_monitor #(
    .SYNC_STAGES(2), .MIN_GAP(1), .MAX_GAP(4), .LOCK_COUNT(8), .GAP_W(8), .CNT_W(16)
  ) u_dut (
    .Bclk  (Bclk),
    .reset (reset_a),
    .bus   (bus_a)
  );

  cd_toggle_monitor #(
    .SYNC_STAGES(2), .MIN_GAP(2), .MAX_GAP(4), .LOCK_COUNT(8), .GAP_W(8), .CNT_W(3)
  ) u_dut_b (
    .Bclk  (Bclk),
    .reset (reset_b),
    .bus   (bus_b)
  );

  task automatic tick();
    @(posedge Bclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic toggle_a(input int n, input int spacing);
    repeat (n) begin
      bus_a.din = ~bus_a.din;
      repeat (spacing) tick();
    end
  endtask

  task automatic toggle_b(input int n, input int spacing);
    repeat (n) begin
      bus_b.din = ~bus_b.din;
      repeat (spacing) tick();
    end
  endtask

  initial begin
    bus_a.din = 1'b0; bus_a.clear_errs = 1'b0;
    bus_b.din = 1'b0; bus_b.clear_errs = 1'b0;

    // ---- Instance A: reset state
    repeat (3) tick();
    chk("a_rst_pulse",  bus_a.toggle_pulse, 0);
    chk("a_rst_gap",    bus_a.gap, 0);
    chk("a_rst_gvalid", bus_a.gap_valid, 0);
    chk("a_rst_locked", bus_a.locked, 0);
    chk("a_rst_errs",   {bus_a.err_short, bus_a.err_long}, 0);
    chk("a_rst_tcnt",   bus_a.toggle_count, 0);
    chk("a_rst_ecnt",   bus_a.error_count, 0);
    chk("a_rst_state",  u_dut.r_state, ST_IDLE);
    reset_a = 1'b0;
    tick();

    // ---- 12 toggles every 2 cycles: pulse 3 edges after change, gap 2, lock on 8th gap
    for (int t = 1; t <= 26; t++) begin
      if (t % 2 == 1 && t <= 23) bus_a.din = ~bus_a.din;
      tick();
      chk("a_pulse",  bus_a.toggle_pulse, (t >= 3 && t % 2 == 1 && t <= 25));
      chk("a_gvalid", bus_a.gap_valid,    (t >= 5 && t % 2 == 1 && t <= 25));
      chk("a_locked", bus_a.locked,       (t >= 19));
      if (t >= 5 && t % 2 == 1 && t <= 25) chk("a_gap", bus_a.gap, 2);
    end
    chk("a_tcnt12", bus_a.toggle_count, 12);
    chk("a_ecnt0",  bus_a.error_count, 0);

    // ---- Hold din: single err_long 5 cycles after last toggle_pulse
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk("a_tmo_errlong", bus_a.err_long, (j == 4));
      chk("a_tmo_locked",  bus_a.locked,   (j < 4));
    end
    chk("a_tmo_ecnt",  bus_a.error_count, 1);
    chk("a_tmo_state", u_dut.r_state, ST_IDLE);
    bus_a.din = ~bus_a.din;
    repeat (3) tick();
    chk("a_reacq_pulse",  bus_a.toggle_pulse, 1);
    chk("a_reacq_gvalid", bus_a.gap_valid, 0);
    chk("a_reacq_errlong", bus_a.err_long, 0);
    chk("a_reacq_state",  u_dut.r_state, ST_ACQ);

    // ---- Relock, then a 6-cycle gap: err_long at timeout only
    toggle_a(8, 2);
    tick();
    chk("a_relock", bus_a.locked, 1);
    for (int r = 4; r <= 10; r++) begin
      if (r == 7) bus_a.din = ~bus_a.din;
      tick();
      chk("a_g6_errlong", bus_a.err_long, (r == 8));
      chk("a_g6_pulse",   bus_a.toggle_pulse, (r == 9));
      chk("a_g6_gvalid",  bus_a.gap_valid, 0);
      chk("a_g6_locked",  bus_a.locked, (r < 8));
    end
    chk("a_g6_ecnt", bus_a.error_count, 2);

    // ---- Reset mid-ACQ
    toggle_a(3, 2);
    tick();
    chk("a_acq_good",  u_dut.r_good_cnt, 3);
    chk("a_acq_state", u_dut.r_state, ST_ACQ);
    reset_a = 1'b1;
    bus_a.din = 1'b0;
    tick();
    chk("a_mrst_state", u_dut.r_state, ST_IDLE);
    chk("a_mrst_good",  u_dut.r_good_cnt, 0);
    chk("a_mrst_tcnt",  bus_a.toggle_count, 0);
    chk("a_mrst_ecnt",  bus_a.error_count, 0);
    chk("a_mrst_gap",   bus_a.gap, 0);
    reset_a = 1'b0;
    repeat (2) tick();
    chk("a_post_pulse", bus_a.toggle_pulse, 0);
    bus_a.din = ~bus_a.din;
    repeat (3) tick();
    chk("a_post_pulse1",  bus_a.toggle_pulse, 1);
    chk("a_post_gvalid",  bus_a.gap_valid, 0);
    chk("a_post_state",   u_dut.r_state, ST_ACQ);
    chk("a_post_tcnt",    bus_a.toggle_count, 1);

    // ---- Instance B (MIN_GAP=2, CNT_W=3)
    chk("b_rst_tcnt", bus_b.toggle_count, 0);
    chk("b_rst_ecnt", bus_b.error_count, 0);
    reset_b = 1'b0;
    tick();
    toggle_b(9, 2);
    chk("b_prelock", bus_b.locked, 0);
    tick();
    chk("b_lock",     bus_b.locked, 1);
    chk("b_tcnt_wrap", bus_b.toggle_count, 1);
    chk("b_ecnt0",    bus_b.error_count, 0);

    // Two toggles one cycle apart -> err_short, gap 1
    bus_b.din = ~bus_b.din;
    tick();
    bus_b.din = ~bus_b.din;
    repeat (2) tick();
    chk("b_p_pulse", bus_b.toggle_pulse, 1);
    chk("b_p_gap",   bus_b.gap, 3);
    chk("b_p_short", bus_b.err_short, 0);
    tick();
    chk("b_short",     bus_b.err_short, 1);
    chk("b_short_gap", bus_b.gap, 1);
    chk("b_short_gv",  bus_b.gap_valid, 1);
    chk("b_short_lck", bus_b.locked, 1);
    chk("b_short_ecnt", bus_b.error_count, 1);

    // Toggle on the timeout threshold: normal long gap, stays locked
    repeat (2) tick();
    bus_b.din = ~bus_b.din;
    repeat (3) tick();
    chk("b_thr_gap",  bus_b.gap, 5);
    chk("b_thr_long", bus_b.err_long, 1);
    chk("b_thr_gv",   bus_b.gap_valid, 1);
    chk("b_thr_lck",  bus_b.locked, 1);
    chk("b_thr_ecnt", bus_b.error_count, 2);

    // Seven more short errors: error_count saturates at 3'h7
    toggle_b(8, 1);
    repeat (2) tick();
    chk("b_sat_ecnt", bus_b.error_count, 7);
    chk("b_sat_lck",  bus_b.locked, 1);

    // clear_errs coinciding with an error wins
    bus_b.din = ~bus_b.din;
    tick();
    bus_b.din = ~bus_b.din;
    repeat (2) tick();
    bus_b.clear_errs = 1'b1;
    tick();
    chk("b_clr_short", bus_b.err_short, 1);
    chk("b_clr_ecnt",  bus_b.error_count, 0);
    chk("b_clr_tcnt",  bus_b.toggle_count, 6);
    bus_b.clear_errs = 1'b0;
    tick();
    chk("b_clr_hold", bus_b.error_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
